// File: rtl/shift_sequencer_if.sv
// Handshake bundle between a shift_sequencer and its controller, including the
// chain end bits fed back from the mc10141 slices.
interface shift_sequencer_if #(
    parameter int CNT_W = 6
);
    logic             start;
    logic             load;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic [1:0]       fill;
    logic             abort;
    logic             q0;
    logic             q35;
    logic [1:0]       mode;
    logic             fillHi;
    logic             fillLo;
    logic             ready;
    logic             done;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, load, count, dir, fill, abort, q0, q35,
        input  mode, fillHi, fillLo, ready, done, remaining
    );

    modport slave (
        input  start, load, count, dir, fill, abort, q0, q35,
        output mode, fillHi, fillLo, ready, done, remaining
    );
endinterface

// File: rtl/shift_sequencer.sv
// Sequencer for a 36-bit mc10141 chain: optional LOAD, N shifts, then HOLD + done.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN enables the rotate fill (fill=11).
module shift_sequencer #(
    parameter int CNT_W = 6
) (
    input logic             clk,
    input logic             rstN,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0] M_LOAD   = 2'b00;
    localparam logic [1:0] M_SHIFTL = 2'b01;
    localparam logic [1:0] M_SHIFTR = 2'b10;
    localparam logic [1:0] M_HOLD   = 2'b11;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_rem, w_rem_next;
    logic             r_dir, w_dir_next;
    logic [1:0]       r_fill, w_fill_next;
    logic             w_fill_hi, w_fill_lo;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_fill  <= 2'b00;
        end else begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
            r_dir   <= w_dir_next;
            r_fill  <= w_fill_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_dir_next   = r_dir;
        w_fill_next  = r_fill;
        case (r_state)
            S_IDLE: begin
                // abort in IDLE masks a simultaneous start
                if (bus.start && !bus.abort) begin
                    w_dir_next  = bus.dir;
                    w_fill_next = bus.fill;
                    w_rem_next  = bus.count;
                    if (bus.load)              w_state_next = S_LOAD;
                    else if (bus.count != '0)  w_state_next = S_SHIFT;
                    else                       w_state_next = S_DONE;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    w_state_next = S_DONE;
                    w_rem_next   = '0;
                end else if (r_rem != '0) begin
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_SHIFT: begin
                if (bus.abort || r_rem <= CNT_W'(1)) begin
                    w_state_next = S_DONE;
                    w_rem_next   = '0;
                end else begin
                    w_rem_next   = r_rem - CNT_W'(1);
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mode = M_HOLD;
        case (r_state)
            S_LOAD:  bus.mode = M_LOAD;
            S_SHIFT: bus.mode = r_dir ? M_SHIFTL : M_SHIFTR;
            default: bus.mode = M_HOLD;
        endcase
    end

    // Fill decode uses the live chain end bits; slices capture it on the next edge.
    always_comb begin
        w_fill_hi = 1'b0;
        w_fill_lo = 1'b0;
        case (r_fill)
            2'b01: begin
                w_fill_hi = 1'b1;
                w_fill_lo = 1'b1;
            end
            2'b10: w_fill_hi = r_dir & bus.q0;
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b11: begin
                if (r_dir) w_fill_hi = bus.q35;
                else       w_fill_lo = bus.q0;
            end
`endif
            default: ;
        endcase
    end

`ifndef SHIFT_SEQ_ROTATE_EN
    logic w_unused_q35;
    assign w_unused_q35 = bus.q35;
`endif

    assign bus.fillHi    = w_fill_hi;
    assign bus.fillLo    = w_fill_lo;
    assign bus.ready     = (r_state == S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.remaining = r_rem;
endmodule
